// File: rtl/call_panel.sv
// ---------------------------------------------------------------------------
// call_panel
//   Request-source side of the lift input buffer. Each of the seven call
//   buttons is synchronised, debounced and latched as a pending call with a
//   lamp. Pending calls are serialised as 3-bit floor codes, one at a time,
//   in round-robin order. A fixed idle gap follows every code. A call clears
//   when the lift FSM reports that floor as served.
//
// Parameters
//   DEB_DIV  clk cycles per debounce sample tick (>= 2)
//   GAP_CYC  forced idle cycles after each emitted code (>= 1)
//
// Ports
//   clk           in   1  system clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   btn           in   7  raw async buttons, btn[i] requests floor code i+1
//   served_vld    in   1  one-cycle strobe, served_floor has been served
//   served_floor  in   3  served floor code 1..7 (0 is ignored)
//   req_code      out  3  0 = no request, 1..7 = floor, one cycle per code
//   lamp          out  7  lamp[i] = 1 while floor i+1 is pending or issued
//
// Floor slot FSM (one per floor)
//   state     | meaning
//   S_IDLE    | no call for this floor
//   S_PEND    | call latched, waiting for the emitter
//   S_ISSUED  | code sent to the buffer, waiting for served
//
// Emitter FSM
//   state     | meaning
//   E_IDLE    | scanning for a pending slot from the round-robin pointer
//   E_SEND    | req_code holds the selected floor for this one cycle
//   E_GAP     | req_code forced to 0 for GAP_CYC cycles
// ---------------------------------------------------------------------------
module call_panel #(
  parameter int DEB_DIV = 1000,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn,
  input  logic       served_vld,
  input  logic [2:0] served_floor,
  output logic [2:0] req_code,
  output logic [6:0] lamp
);

  localparam int DEB_W = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_ISSUED = 2'd2;

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_SEND = 2'd1;
  localparam logic [1:0] E_GAP  = 2'd2;

  // -------------------------------------------------------------------------
  // Synchroniser and debounce
  // -------------------------------------------------------------------------
  logic [6:0]       r_sync1;
  logic [6:0]       r_sync2;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [3:0]       r_hist [7];
  logic [3:0]       w_hist_nxt [7];
  logic             w_tick;
  logic [6:0]       w_press;

  assign w_tick = (r_deb_cnt == DEB_W'(DEB_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      if (w_tick) r_deb_cnt <= '0;
      else        r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // A press is the history pattern low followed by three highs. A long hold
  // fills the history with ones, so it can match 0111 only once.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      w_hist_nxt[i] = {r_hist[i][2:0], r_sync2[i]};
      w_press[i]    = w_tick && (w_hist_nxt[i] == 4'b0111);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) r_hist[i] <= 4'b0000;
    end else if (w_tick) begin
      for (int i = 0; i < 7; i++) r_hist[i] <= w_hist_nxt[i];
    end
  end

  // -------------------------------------------------------------------------
  // Floor slots
  // -------------------------------------------------------------------------
  logic [1:0] r_slot_st [7];
  logic [1:0] w_slot_nxt [7];
  logic [6:0] r_lamp;
  logic [6:0] w_pend;
  logic [6:0] w_send;
  logic [6:0] w_served;

  logic [1:0] r_emit_st;
  logic [2:0] r_sel_idx;
  logic [2:0] r_ptr;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [2:0] r_req_code;

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      w_pend[i]   = (r_slot_st[i] == S_PEND);
      w_send[i]   = (r_emit_st == E_SEND) && (r_sel_idx == 3'(i));
      w_served[i] = served_vld && (served_floor == 3'(i + 1));

      w_slot_nxt[i] = r_slot_st[i];
      case (r_slot_st[i])
        S_IDLE:   if (w_press[i]) w_slot_nxt[i] = S_PEND;
        S_PEND:   if (w_send[i])  w_slot_nxt[i] = S_ISSUED;
        S_ISSUED: w_slot_nxt[i] = S_ISSUED;
        default:  w_slot_nxt[i] = S_IDLE;
      endcase
      // Served overrides both a new press and the issue in the same cycle.
      if (w_served[i]) w_slot_nxt[i] = S_IDLE;
    end
  end

  // The lamp is registered from the next state so it lines up with the slot
  // state itself rather than trailing it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) r_slot_st[i] <= S_IDLE;
      r_lamp <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        r_slot_st[i] <= w_slot_nxt[i];
        r_lamp[i]    <= (w_slot_nxt[i] != S_IDLE);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin selection: first pending slot at or after r_ptr, wrapping
  // 6 -> 0. Scanning the offsets downward lets the nearest one win.
  // -------------------------------------------------------------------------
  logic       w_any_pend;
  logic [2:0] w_sel_idx;
  logic [3:0] w_rr_sum;

  always_comb begin
    w_any_pend = 1'b0;
    w_sel_idx  = 3'd0;
    w_rr_sum   = 4'd0;
    for (int k = 6; k >= 0; k--) begin
      w_rr_sum = {1'b0, r_ptr} + 4'(k);
      if (w_rr_sum >= 4'd7) w_rr_sum = w_rr_sum - 4'd7;
      if (w_pend[w_rr_sum[2:0]]) begin
        w_any_pend = 1'b1;
        w_sel_idx  = w_rr_sum[2:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Emitter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_emit_st  <= E_IDLE;
      r_sel_idx  <= 3'd0;
      r_ptr      <= 3'd0;
      r_gap_cnt  <= '0;
      r_req_code <= 3'd0;
    end else begin
      case (r_emit_st)
        E_IDLE: begin
          r_req_code <= 3'd0;
          if (w_any_pend) begin
            r_sel_idx  <= w_sel_idx;
            r_req_code <= w_sel_idx + 3'd1;
            r_emit_st  <= E_SEND;
          end
        end
        E_SEND: begin
          r_req_code <= 3'd0;
          r_ptr      <= (r_sel_idx == 3'd6) ? 3'd0 : r_sel_idx + 3'd1;
          r_gap_cnt  <= GAP_W'(GAP_CYC - 1);
          r_emit_st  <= E_GAP;
        end
        E_GAP: begin
          r_req_code <= 3'd0;
          if (r_gap_cnt == '0) r_emit_st <= E_IDLE;
          else                 r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: begin
          r_req_code <= 3'd0;
          r_emit_st  <= E_IDLE;
        end
      endcase
    end
  end

  assign req_code = r_req_code;
  assign lamp     = r_lamp;

endmodule

// File: tb/tb_call_panel.sv
module tb_call_panel;

  localparam int DEB = 4;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] btn = '0;
  logic       served_vld = 1'b0;
  logic [2:0] served_floor = '0;
  logic [2:0] req_code;
  logic [6:0] lamp;

  always #5 clk = ~clk;

  call_panel #(.DEB_DIV(DEB), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .served_vld(served_vld),
    .served_floor(served_floor), .req_code(req_code), .lamp(lamp)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: button levels delayed two edges, a count of consecutive
  // high samples per button (press when it reaches 3), slot states as ints,
  // and the emitter as "code sent at edge e, next selection at e+GAP+2".
  // -------------------------------------------------------------------------
  int         m_edges;
  logic [6:0] m_d1, m_d2;
  int         m_run [7];
  int         m_slot [7];          // 0 idle, 1 pending, 2 issued
  int         m_ptr;
  int         m_next_sel;
  bit         m_sending;
  int         m_send_idx;
  int         m_req;
  logic [6:0] m_lamp;
  bit         m_press_nxt [7];
  bit         model_on = 1'b0;

  task automatic model_reset();
    m_edges = 0; m_d1 = '0; m_d2 = '0; m_ptr = 0; m_next_sel = 0;
    m_sending = 0; m_send_idx = 0; m_req = 0; m_lamp = '0;
    for (int i = 0; i < 7; i++) begin
      m_run[i] = 0; m_slot[i] = 0; m_press_nxt[i] = 0;
    end
  endtask

  task automatic model_step();
    int  e;
    bit  tick;
    bit  press [7];
    int  old_slot [7];
    bit  send_now;
    int  sidx;
    int  cand;
    e = m_edges;
    tick = ((e % DEB) == DEB - 1);
    send_now = 0;
    sidx = -1;
    for (int i = 0; i < 7; i++) begin
      old_slot[i] = m_slot[i];
      press[i] = 0;
      if (tick) begin
        if (m_d2[i]) begin
          if (m_run[i] < 1000) m_run[i]++;
          if (m_run[i] == 3) press[i] = 1;
        end else m_run[i] = 0;
      end
    end
    if (m_sending) begin
      send_now = 1; sidx = m_send_idx;
      m_ptr = (sidx + 1) % 7;
      m_sending = 0; m_req = 0;
    end else begin
      m_req = 0;
      if (e >= m_next_sel) begin
        for (int k = 0; k < 7; k++) begin
          cand = (m_ptr + k) % 7;
          if (!m_sending && old_slot[cand] == 1) begin
            m_sending = 1; m_send_idx = cand; m_req = cand + 1;
            m_next_sel = e + GAP + 2;
          end
        end
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (served_vld && served_floor == 3'(i + 1)) m_slot[i] = 0;
      else if (old_slot[i] == 1 && send_now && sidx == i) m_slot[i] = 2;
      else if (old_slot[i] == 0 && press[i]) m_slot[i] = 1;
      m_lamp[i] = (m_slot[i] != 0);
    end
    m_d2 = m_d1;
    m_d1 = btn;
    m_edges = e + 1;
    for (int i = 0; i < 7; i++)
      m_press_nxt[i] = ((m_edges % DEB) == DEB - 1) && m_d2[i] && (m_run[i] == 2);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("cyc_req", 32'(req_code), 32'(m_req));
        check("cyc_lamp", 32'(lamp), 32'(m_lamp));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  int code_val[$];
  int code_at[$];
  int cyc_ctr = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc_ctr++;
      if (req_code != 3'd0) begin
        code_val.push_back(int'(req_code));
        code_at.push_back(cyc_ctr);
      end
    end
  endtask

  task automatic clear_codes();
    code_val.delete();
    code_at.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn = '0; served_vld = 1'b0; served_floor = '0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic serve(input int fl);
    served_vld = 1'b1; served_floor = 3'(fl);
    cyc(1);
    served_vld = 1'b0; served_floor = '0;
  endtask

  task automatic check_codes(input string name, input int n, input int c0, input int c1, input int c2);
    int ce [3];
    ce[0] = c0; ce[1] = c1; ce[2] = c2;
    check({name, "_count"}, 32'(code_val.size()), 32'(n));
    for (int j = 0; j < n && j < code_val.size(); j++) begin
      check({name, "_code"}, 32'(code_val[j]), 32'(ce[j]));
      if (j > 0) check({name, "_spacing"}, 32'(code_at[j] - code_at[j-1]), 32'(GAP + 2));
    end
  endtask

  typedef struct {
    logic [6:0] mask;
    int         hold;
    int         n_exp;
    int         c0;
    int         c1;
    int         c2;
    logic [6:0] lamp_exp;
  } vec_t;

  vec_t tbl [3];

  initial begin
    bit found;
    tbl[0] = '{7'b0000100, 24, 1, 3, 0, 0, 7'b0000100};
    tbl[1] = '{7'b1010001, 24, 3, 1, 5, 7, 7'b1010001};
    tbl[2] = '{7'b0100010, 24, 2, 2, 6, 0, 7'b0100010};

    do_reset();
    model_on = 1'b1;
    check("reset_req", 32'(req_code), 32'd0);
    check("reset_lamp", 32'(lamp), 32'd0);

    // Table: reset, hold a mask, collect the codes and the final lamps.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      clear_codes();
      btn = tbl[t].mask;
      cyc(tbl[t].hold);
      btn = '0;
      cyc(60);
      check_codes("tbl", tbl[t].n_exp, tbl[t].c0, tbl[t].c1, tbl[t].c2);
      check("tbl_lamp", 32'(lamp), 32'(tbl[t].lamp_exp));
    end

    // Single press latency: code appears the cycle after the lamp rises.
    do_reset();
    clear_codes();
    btn = 7'b0000100;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1);
      if (lamp[2]) found = 1;
    end
    check("single_lamp_rise", 32'(found), 32'd1);
    cyc(1);
    check("single_req", 32'(req_code), 32'd3);
    cyc(1);
    check("single_req_drop", 32'(req_code), 32'd0);
    clear_codes();
    cyc(30);
    btn = '0;
    cyc(30);
    check("single_no_repeat", 32'(code_val.size()), 32'd0);

    // Duplicate press while issued: no new code; then serve and re-press.
    btn = 7'b0000100; cyc(24); btn = '0; cyc(40);
    check("dup_no_code", 32'(code_val.size()), 32'd0);
    check("dup_lamp_on", 32'(lamp[2]), 32'd1);
    serve(3);
    check("dup_served_lamp", 32'(lamp[2]), 32'd0);
    clear_codes();
    btn = 7'b0000100; cyc(24); btn = '0; cyc(30);
    check_codes("dup_repress", 1, 3, 0, 0);

    // Round-robin and the wrap from 7 back to pointer 0.
    do_reset();
    clear_codes();
    btn = 7'b1010001; cyc(24); btn = '0; cyc(50);
    check_codes("rr_first", 3, 1, 5, 7);
    serve(1); serve(5); serve(7);
    check("rr_cleared", 32'(lamp), 32'd0);
    clear_codes();
    btn = 7'b1000001; cyc(24); btn = '0; cyc(40);
    check_codes("rr_wrap", 2, 1, 7, 0);

    // Bounce: two ticks high, two low, two high never makes a press.
    do_reset();
    clear_codes();
    btn = 7'b0001000; cyc(8);
    btn = '0;         cyc(8);
    btn = 7'b0001000; cyc(8);
    btn = '0;         cyc(40);
    check("bounce_codes", 32'(code_val.size()), 32'd0);
    check("bounce_lamp", 32'(lamp), 32'd0);

    // Press and served for floor 2 on the same edge.
    do_reset();
    clear_codes();
    btn = 7'b0000010;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1);
      if (m_press_nxt[1]) found = 1;
    end
    check("simul_press_seen", 32'(found), 32'd1);
    served_vld = 1'b1; served_floor = 3'd2;
    cyc(1);
    served_vld = 1'b0; served_floor = '0;
    check("simul_lamp", 32'(lamp[1]), 32'd0);
    cyc(30);
    btn = '0;
    cyc(10);
    check("simul_no_code", 32'(code_val.size()), 32'd0);

    // Reset during the gap with two calls outstanding.
    do_reset();
    clear_codes();
    btn = 7'b0010001;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1);
      if (req_code != 3'd0) found = 1;
    end
    check("rg_first_seen", 32'(found), 32'd1);
    check("rg_first_code", 32'(req_code), 32'd1);
    cyc(2);
    check("rg_lamp_before", 32'(lamp), 32'h11);
    #2 rst_n = 1'b0;
    btn = '0;
    #1;
    check("rg_req_now", 32'(req_code), 32'd0);
    check("rg_lamp_now", 32'(lamp), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    clear_codes();
    cyc(60);
    check("rg_quiet", 32'(code_val.size()), 32'd0);

    // Random stimulus against the model, with one reset in the middle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      if ($urandom_range(0, 11) == 0) btn[$urandom_range(0, 6)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        served_vld = 1'b1;
        served_floor = 3'($urandom_range(0, 7));
      end else begin
        served_vld = 1'b0;
        served_floor = '0;
      end
      cyc(1);
    end

    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
